// File: rtl/sram_stream_adapter_pkg.sv
// Shared constants and helpers for the SRAM stream adapter.
// Contents:
//   MaxLatency  - largest SRAM read latency the tracking pipe supports
//   addr_width  - word-address width for a macro of a given depth (at least 1)
package sram_stream_adapter_pkg;

   localparam int unsigned MaxLatency = 8;

   function automatic int unsigned addr_width(input int unsigned num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small response FIFO with its head entry read straight from storage registers.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset (clears all entries)
//   push_i/data_i - write one entry
//   pop_i         - drop the head entry (ignored when empty)
//   data_o        - head entry
//   full_o        - Depth entries held
//   empty_o       - no entries held
module sram_rsp_fifo #(
   parameter int unsigned Depth = 3,
   parameter type         rsp_t = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  rsp_t data_i,
   input  logic pop_i,
   output rsp_t data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   rsp_t                r_mem [Depth];
   logic [PtrWidth-1:0] r_wptr;
   logic [PtrWidth-1:0] r_rptr;
   logic [CntWidth-1:0] r_cnt;
   logic                w_push;
   logic                w_pop;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign empty_o = (r_cnt == '0);
   assign full_o  = (r_cnt == CntWidth'(Depth));
   assign w_pop   = pop_i & ~empty_o;
   // A full FIFO may still take a push in the cycle its head leaves.
   assign w_push  = push_i & (~full_o | w_pop);
   assign data_o  = r_mem[r_rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (w_pop) r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CntWidth'(1);
            2'b01:   r_cnt <= r_cnt - CntWidth'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/sram_stream_adapter.sv
// Valid/ready front end for one port of a fixed-latency SRAM macro.
// Requests are forwarded to the SRAM in the cycle they are accepted; a Latency-deep
// tracking pipe marks when read data arrives, and every request yields one in-order
// response through a credit-protected FIFO, so stalled read data is never lost.
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   req_valid_i/req_ready_o - request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_be_i - request fields
//   rsp_valid_o/rsp_ready_i - response handshake
//   rsp_we_o, rsp_rdata_o   - 1 = write ack (rdata 0), 0 = read data
//   sram_*_o, sram_rdata_i  - SRAM macro port
module sram_stream_adapter
   import sram_stream_adapter_pkg::*;
#(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = 3,
   parameter int unsigned AddrWidth = addr_width(NumWords),
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_we_o,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   localparam int unsigned CntWidth = $clog2(RspDepth + 1);

   typedef struct packed {
      logic                 we;
      logic [DataWidth-1:0] rdata;
   } rsp_t;

   if ((Latency < 1) || (Latency > MaxLatency)) begin : g_bad_latency
      $error("sram_stream_adapter: Latency must be in 1..%0d", MaxLatency);
   end
   if (RspDepth < Latency + 1) begin : g_bad_depth
      $error("sram_stream_adapter: RspDepth must be at least Latency+1");
   end

   // Credits: in-flight accesses plus buffered responses.
   logic [CntWidth-1:0] r_cnt;
   logic [CntWidth-1:0] w_cnt_d;
   logic [Latency-1:0]  r_pipe_vld;
   logic [Latency-1:0]  r_pipe_we;
   logic [Latency-1:0]  w_pipe_vld_d;
   logic [Latency-1:0]  w_pipe_we_d;
   logic                w_accept;
   logic                w_pop;
   logic                w_push;
   logic                w_full;
   logic                w_empty;
   rsp_t                w_push_data;
   rsp_t                w_head;

   // Ready depends on registered credits only, never on rsp_ready_i.
   assign req_ready_o = (r_cnt < CntWidth'(RspDepth));
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_pop       = rsp_valid_o & rsp_ready_i;

   assign sram_req_o   = w_accept;
   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = req_be_i;

   always_comb begin
      w_cnt_d = r_cnt;
      if (w_accept && !w_pop) begin
         w_cnt_d = r_cnt + CntWidth'(1);
      end else if (!w_accept && w_pop) begin
         w_cnt_d = r_cnt - CntWidth'(1);
      end
   end

   always_comb begin
      w_pipe_vld_d    = r_pipe_vld << 1;
      w_pipe_we_d     = r_pipe_we << 1;
      w_pipe_vld_d[0] = w_accept;
      w_pipe_we_d[0]  = req_we_i;
   end

   // The last pipe stage lines up with the edge on which SRAM read data is valid.
   always_comb begin
      w_push            = r_pipe_vld[Latency-1];
      w_push_data.we    = r_pipe_we[Latency-1];
      w_push_data.rdata = r_pipe_we[Latency-1] ? '0 : sram_rdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt      <= '0;
         r_pipe_vld <= '0;
         r_pipe_we  <= '0;
      end else begin
         r_cnt      <= w_cnt_d;
         r_pipe_vld <= w_pipe_vld_d;
         r_pipe_we  <= w_pipe_we_d;
      end
   end

   sram_rsp_fifo #(
      .Depth (RspDepth),
      .rsp_t (rsp_t)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .data_i  (w_push_data),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign rsp_valid_o = ~w_empty;
   assign rsp_we_o    = w_head.we;
   assign rsp_rdata_o = w_head.rdata;

   // Credits guarantee a slot for every response that comes out of the pipe.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_push |-> (!w_full || w_pop));

endmodule
